// File: rtl/cic_dec2_if.sv
// Sample bus between the two-channel mixer and the dual I/Q CIC decimator.
// The master drives the four input streams; the slave returns the decimated samples.
interface cic_dec2_if #(
    parameter int OUT_W = 24
);
    logic                    in_valid;
    logic signed [17:0]      in0_i;
    logic signed [17:0]      in0_q;
    logic signed [17:0]      in1_i;
    logic signed [17:0]      in1_q;
    logic signed [OUT_W-1:0] out0_i;
    logic signed [OUT_W-1:0] out0_q;
    logic signed [OUT_W-1:0] out1_i;
    logic signed [OUT_W-1:0] out1_q;
    logic                    out_valid;

    modport master (
        output in_valid, in0_i, in0_q, in1_i, in1_q,
        input  out0_i, out0_q, out1_i, out1_q, out_valid
    );

    modport slave (
        input  in_valid, in0_i, in0_q, in1_i, in1_q,
        output out0_i, out0_q, out1_i, out1_q, out_valid
    );
endinterface

// File: rtl/cic_dec2.sv
// Dual-channel I/Q CIC decimator, R = 2^k: per-stream integrators and one time-shared comb.
// Optional macro CIC_OUT_ROUND_EN selects round-half-up output scaling instead of truncation.
module cic_dec2 #(
    parameter int N        = 3,
    parameter int MIN_LOG2 = 3,
    parameter int MAX_LOG2 = 6,
    parameter int OUT_W    = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rate_log2,
    cic_dec2_if.slave  bus
);
    localparam int W       = 18 + N * MAX_LOG2;
    localparam int GAIN_SH = OUT_W - 18;
    localparam int CNT_W   = MAX_LOG2;

    typedef enum logic [2:0] {S_IDLE, S_C0, S_C1, S_C2, S_C3, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              k_req, k_act;
    logic [CNT_W-1:0]        cnt, cnt_last;
    logic                    block_end;
    logic signed [17:0]      in_s      [4];
    logic signed [W-1:0]     integ     [4][N];
    logic signed [W-1:0]     integ_nxt [4][N];
    logic signed [W-1:0]     snap      [4];
    logic signed [W-1:0]     dly       [4][N];
    logic signed [W-1:0]     comb_x    [N];
    logic signed [W-1:0]     comb_acc;
    logic signed [W-1:0]     rounded;
    logic signed [OUT_W-1:0] scaled;
    logic signed [OUT_W-1:0] stage     [4];
    logic signed [OUT_W-1:0] out_q     [4];
    logic [5:0]              sh;
    logic [1:0]              sel;
    logic                    comb_en;
    logic                    out_valid_q;

    assign in_s[0] = bus.in0_i;
    assign in_s[1] = bus.in0_q;
    assign in_s[2] = bus.in1_i;
    assign in_s[3] = bus.in1_q;

    always_comb begin
        if (rate_log2 < 3'(MIN_LOG2))      k_req = 3'(MIN_LOG2);
        else if (rate_log2 > 3'(MAX_LOG2)) k_req = 3'(MAX_LOG2);
        else                               k_req = rate_log2;
    end

    assign cnt_last  = CNT_W'((1 << k_act) - 1);
    assign block_end = bus.in_valid && (cnt == cnt_last);

    // Integrator cascade: each stage adds the freshly updated output of the stage before it.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            integ_nxt[s][0] = integ[s][0] + W'(in_s[s]);
            for (int j = 1; j < N; j++)
                integ_nxt[s][j] = integ[s][j] + integ_nxt[s][j-1];
        end
    end

    always_comb begin
        sel     = 2'd0;
        comb_en = 1'b1;
        case (state_q)
            S_C0:    sel = 2'd0;
            S_C1:    sel = 2'd1;
            S_C2:    sel = 2'd2;
            S_C3:    sel = 2'd3;
            default: comb_en = 1'b0;
        endcase
        // NOTE: comb_acc is re-assigned stage by stage with blocking '=' so that each comb
        // stage sees the previous stage's difference within the same cycle.
        comb_acc = snap[sel];
        for (int j = 0; j < N; j++) begin
            comb_x[j] = comb_acc;
            comb_acc  = comb_acc - dly[sel][j];
        end
        sh = 6'(N * int'(k_act) - GAIN_SH);
`ifdef CIC_OUT_ROUND_EN
        rounded = comb_acc + (W'(1) << (sh - 6'd1));
`else
        rounded = comb_acc;
`endif
        scaled = OUT_W'(rounded >>> sh);
    end

    always_comb begin
        // NOTE: default first, so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (block_end) state_d = S_C0;
            S_C0:    state_d = S_C1;
            S_C1:    state_d = S_C2;
            S_C2:    state_d = S_C3;
            S_C3:    state_d = S_OUT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || (k_req != k_act)) begin
            // NOTE: the small state arrays must start at zero for the CIC response to be exact,
            // so they are cleared explicitly like any other register.
            for (int s = 0; s < 4; s++) begin
                for (int j = 0; j < N; j++) begin
                    integ[s][j] <= '0;
                    dly[s][j]   <= '0;
                end
                snap[s]  <= '0;
                stage[s] <= '0;
                if (!rst) out_q[s] <= '0;
            end
            cnt         <= '0;
            k_act       <= k_req;
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_q == S_OUT);
            if (bus.in_valid) begin
                integ <= integ_nxt;
                cnt   <= block_end ? '0 : cnt + 1'b1;
                if (block_end)
                    for (int s = 0; s < 4; s++) snap[s] <= integ_nxt[s][N-1];
            end
            if (comb_en) begin
                for (int j = 0; j < N; j++) dly[sel][j] <= comb_x[j];
                stage[sel] <= scaled;
            end
            if (state_q == S_OUT) out_q <= stage;
        end
    end

    assign bus.out0_i    = out_q[0];
    assign bus.out0_q    = out_q[1];
    assign bus.out1_i    = out_q[2];
    assign bus.out1_q    = out_q[3];
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_cic_dec2.sv
// Bench for cic_dec2: a convolution model of the CIC response, checked every cycle,
// plus hand-computed literal results for the directed scenarios.
module tb_cic_dec2;
    localparam int N     = 3;
    localparam int OUT_W = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] rate_log2 = 3'd3;

    cic_dec2_if #(.OUT_W(OUT_W)) bus ();

    cic_dec2 #(.N(N), .MIN_LOG2(3), .MAX_LOG2(6), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rate_log2 (rate_log2),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int              at;
        logic [3:0][31:0] v;
    } exp_t;

    exp_t   pend[$];
    int     edge_n  = 0;
    int     k_m     = 3;
    int     nsamp   = 0;
    int     hist [4][0:4095];
    longint h [0:255];
    int     h_len   = 1;
    int     last_out [4];
    bit     started = 1'b0;
    int     got [4][0:255];
    int     n_out   = 0;

    function automatic int clampk(int x);
        return (x < 3) ? 3 : (x > 6) ? 6 : x;
    endfunction

    // Impulse response of N cascaded length-R moving sums: (1 + z + ... + z^(R-1))^N.
    function automatic void build_h(int k);
        longint t [0:255];
        int r = 1 << k;
        for (int i = 0; i < 256; i++) h[i] = 0;
        h[0]  = 1;
        h_len = 1;
        for (int st = 0; st < N; st++) begin
            for (int i = 0; i < 256; i++) t[i] = 0;
            for (int i = 0; i < h_len; i++)
                for (int j = 0; j < r; j++) t[i+j] += h[i];
            h_len += r - 1;
            for (int i = 0; i < 256; i++) h[i] = t[i];
        end
    endfunction

    function automatic int model_out(int s, int n);
        longint y = 0;
        int     shv = N * k_m - (OUT_W - 18);
        for (int j = 0; j < h_len && j <= n; j++) y += h[j] * longint'(hist[s][n-j]);
`ifdef CIC_OUT_ROUND_EN
        y += longint'(1) << (shv - 1);
`endif
        return int'(y >>> shv);
    endfunction

    function automatic void model_clear(bit outs_too);
        nsamp = 0;
        pend.delete();
        k_m = clampk(int'(rate_log2));
        build_h(k_m);
        if (outs_too) for (int s = 0; s < 4; s++) last_out[s] = 0;
    endfunction

    function automatic int dut_out(int s);
        case (s)
            0:       return int'(bus.out0_i);
            1:       return int'(bus.out0_q);
            2:       return int'(bus.out1_i);
            default: return int'(bus.out1_q);
        endcase
    endfunction

    // One clock: drive, let the edge consume the inputs, then advance the model.
    task automatic step(input bit v, input int a0, input int a1, input int a2, input int a3);
        int   a [4];
        exp_t e;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        bus.in_valid = v;
        bus.in0_i = 18'(a0);
        bus.in0_q = 18'(a1);
        bus.in1_i = 18'(a2);
        bus.in1_q = 18'(a3);
        @(posedge clk);
        edge_n++;
        if (!rst) begin
            model_clear(1'b1);
        end else if (clampk(int'(rate_log2)) != k_m) begin
            model_clear(1'b0);
        end else if (v) begin
            for (int s = 0; s < 4; s++) hist[s][nsamp] = a[s];
            nsamp++;
            if (nsamp % (1 << k_m) == 0) begin
                e.at = edge_n + 5;
                for (int s = 0; s < 4; s++) e.v[s] = model_out(s, nsamp - 1);
                pend.push_back(e);
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (pend.size() > 0 && pend[0].at == edge_n) begin
                check("out_valid strobe", longint'(bus.out_valid), 1);
                for (int s = 0; s < 4; s++) begin
                    check($sformatf("out stream %0d", s), dut_out(s), int'(pend[0].v[s]));
                    last_out[s] = int'(pend[0].v[s]);
                    got[s][n_out % 256] = dut_out(s);
                end
                n_out++;
                void'(pend.pop_front());
            end else begin
                check("out_valid quiet", longint'(bus.out_valid), 0);
                for (int s = 0; s < 4; s++)
                    check($sformatf("hold stream %0d", s), dut_out(s), last_out[s]);
            end
        end
    end

    task automatic do_reset(input int k);
        rate_log2 = 3'(k);
        rst = 1'b0;
        step(1'b0, 0, 0, 0, 0);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 0, 0);
    endtask

`ifdef CIC_OUT_ROUND_EN
    localparam int STEP_LIT = 13;
    localparam int IMP_LIT  = 23;
`else
    localparam int STEP_LIT = 12;
    localparam int IMP_LIT  = 22;
`endif

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in0_i = '0; bus.in0_q = '0; bus.in1_i = '0; bus.in1_q = '0;
        rst = 1'b0;
        repeat (2) step(1'b0, 0, 0, 0, 0);
        started = 1'b1;

        // DC settle, k = 3: 1000 * 2^6 once the 22-tap response is filled.
        do_reset(3);
        base = n_out;
        repeat (48) step(1'b1, 1000, 1000, 1000, 1000);
        idle(8);
        check("dc output count", n_out - base, 6);
        for (int m = 2; m < 6; m++)
            for (int s = 0; s < 4; s++)
                check($sformatf("dc settled m%0d s%0d", m, s), got[s][(base + m) % 256], 64000);

        // Step at the first sample, k = 4: 816 / 64.
        do_reset(4);
        base = n_out;
        repeat (48) step(1'b1, 1, 1, 1, 1);
        idle(8);
        check("step output count", n_out - base, 3);
        for (int s = 0; s < 4; s++)
            check($sformatf("step first s%0d", s), got[s][base % 256], STEP_LIT);

        // Full scale, k = 6 (also via clamping rate_log2 = 7).
        do_reset(7);
        base = n_out;
        repeat (320) step(1'b1, 131071, -131072, 131071, -131072);
        idle(8);
        check("fullscale output count", n_out - base, 5);
        check("fullscale 0I", got[0][(base + 4) % 256], 8388544);
        check("fullscale 0Q", got[1][(base + 4) % 256], -8388608);
        check("fullscale 1I", got[2][(base + 4) % 256], 8388544);
        check("fullscale 1Q", got[3][(base + 4) % 256], -8388608);

        // Channel independence: impulse of 5 on 1Q only, k = 3; first output 5*36/8.
        do_reset(3);
        base = n_out;
        step(1'b1, 0, 0, 0, 5);
        repeat (23) step(1'b1, 0, 0, 0, 0);
        idle(8);
        check("impulse output count", n_out - base, 3);
        check("impulse 1Q first", got[3][base % 256], IMP_LIT);
        for (int m = 0; m < 3; m++)
            for (int s = 0; s < 3; s++)
                check($sformatf("impulse quiet m%0d s%0d", m, s), got[s][(base + m) % 256], 0);

        // in_valid gaps, k = 3 via clamping rate_log2 = 1; junk on invalid cycles is ignored.
        do_reset(1);
        base = n_out;
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) step(1'b1, 1000, 1000, 1000, 1000);
            else            step(1'b0, 77777, -5, 3, 12345);
        end
        idle(8);
        check("gap output count", n_out - base, 4);
        for (int s = 0; s < 4; s++)
            check($sformatf("gap settled s%0d", s), got[s][(base + 3) % 256], 64000);

        // Random data and random gaps, k = 4; checked by the model only.
        do_reset(4);
        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0,
                 int'($urandom_range(262143, 0)) - 131072,
                 int'($urandom_range(262143, 0)) - 131072,
                 int'($urandom_range(262143, 0)) - 131072,
                 int'($urandom_range(262143, 0)) - 131072);
        idle(8);

        // Rate change 3 -> 5 one cycle after a block end aborts that block.
        do_reset(3);
        base = n_out;
        repeat (16) step(1'b1, 1000, -700, 250, 9);
        rate_log2 = 3'd5;
        step(1'b1, 1000, -700, 250, 9);
        repeat (64) step(1'b1, 1000, -700, 250, 9);
        idle(8);
        check("rate change output count", n_out - base, 3);

        // Reset while the sequencer is in C2: no strobe, outputs cleared.
        do_reset(3);
        base = n_out;
        repeat (16) step(1'b1, 1000, 1000, 1000, 1000);
        repeat (2) step(1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1'b0, 0, 0, 0, 0);
        rst = 1'b1;
        idle(10);
        check("reset abort output count", n_out - base, 1);
        check("reset out0_i", dut_out(0), 0);
        check("reset out1_q", dut_out(3), 0);
        check("reset out_valid", longint'(bus.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
